mmul_access_gen: RTL and testbench

// - Synthesizable request sequencer that sits directly upstream of the L1 cache request port.
// - Replays the C[MxN] = A[MxK] * B[KxN] access stream in hardware, one request outstanding:
//   A elements u8, B elements u16, C elements u32.
// - Models ALU cost as stall cycles and exposes cycle/ALU counters so cache timing can be

---
 rtl/mmul_access_gen.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_mmul_access_gen.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmul_access_gen.sv
// mmul_access_gen: replays the C = A * B matrix-multiply access stream as
// cache requests (one outstanding), charging ALU stall cycles between them.
// A is u8, B is u16, C is u32. Define MMUL_CHECKSUM_EN to add the checksum
// output (XOR of every accepted write data word).
module mmul_access_gen #(
  parameter int unsigned M       = 64,
  parameter int unsigned N       = 60,
  parameter int unsigned K       = 32,
  parameter int unsigned A_ADDR  = 0,
  parameter int unsigned ADDR_W  = 19,
  parameter int unsigned MUL_CYC = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              req_valid,
  input  logic              req_ready,
  output logic [2:0]        req_cmd,
  output logic [ADDR_W-1:0] req_addr,
  output logic [31:0]       req_wdata,
  input  logic              resp_valid,
  input  logic [31:0]       resp_rdata,
  output logic [31:0]       cycle_count,
  output logic [31:0]       alu_cycles
`ifdef MMUL_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam int unsigned B_ADDR = A_ADDR + M * K;
  localparam int unsigned C_ADDR = B_ADDR + 2 * K * N;

  localparam int unsigned YW = $clog2(M + 1);
  localparam int unsigned XW = $clog2(N + 1);
  localparam int unsigned KW = $clog2(K + 1);
  localparam int unsigned CW = $clog2(MUL_CYC + 3);

  localparam logic [2:0] CMD_RD8  = 3'd1;
  localparam logic [2:0] CMD_RD16 = 3'd2;
  localparam logic [2:0] CMD_WR32 = 3'd7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_INIT,
    S_RD_A,
    S_WT_A,
    S_RD_B,
    S_WT_B,
    S_MUL,
    S_ACC,
    S_STEP,
    S_WR_C,
    S_WT_C,
    S_ROWSTEP,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [YW-1:0]     r_y;
  logic [XW-1:0]     r_x;
  logic [KW-1:0]     r_k;
  logic [CW-1:0]     r_cnt;
  logic [7:0]        r_a;
  logic [15:0]       r_b;
  logic [31:0]       r_s;

  logic [ADDR_W-1:0] w_a_addr;
  logic [ADDR_W-1:0] w_b_addr;
  logic [ADDR_W-1:0] w_c_addr;
  logic [23:0]       w_prod;
  logic              w_alu_state;
  logic [31:0]       w_cycle_inc;
  logic [31:0]       w_alu_inc;
  logic              w_unused_rdata_hi;

  // Only the low 16 bits of read data carry operand values.
  assign w_unused_rdata_hi = &{1'b0, resp_rdata[31:16]};

  // Element addresses, wrapping modulo 2^ADDR_W by construction of the width.
  assign w_a_addr = ADDR_W'(A_ADDR) + ADDR_W'(r_y) * ADDR_W'(K) + ADDR_W'(r_k);
  assign w_b_addr = ADDR_W'(B_ADDR)
                  + ADDR_W'(2) * (ADDR_W'(r_k) * ADDR_W'(N) + ADDR_W'(r_x));
  assign w_c_addr = ADDR_W'(C_ADDR)
                  + ADDR_W'(4) * (ADDR_W'(r_y) * ADDR_W'(N) + ADDR_W'(r_x));

  // Full 24-bit product; accumulation into 32 bits keeps the carry bits.
  assign w_prod = 24'(r_a) * 24'(r_b);

  assign w_alu_state = (r_state == S_INIT) || (r_state == S_MUL) ||
                       (r_state == S_ACC)  || (r_state == S_STEP) ||
                       (r_state == S_ROWSTEP);

  // Saturating increments for the two performance counters.
  always_comb begin
    w_cycle_inc = (cycle_count == '1) ? cycle_count : cycle_count + 32'd1;
    w_alu_inc   = (alu_cycles  == '1) ? alu_cycles  : alu_cycles  + 32'd1;
  end

  // Sequencer FSM: loop nest y/x/k, request handshake and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_y         <= '0;
      r_x         <= '0;
      r_k         <= '0;
      r_cnt       <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_s         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      req_valid   <= 1'b0;
      req_cmd     <= '0;
      req_addr    <= '0;
      req_wdata   <= '0;
      cycle_count <= '0;
      alu_cycles  <= '0;
`ifdef MMUL_CHECKSUM_EN
      checksum    <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (busy) begin
        cycle_count <= w_cycle_inc;
      end
      if (w_alu_state) begin
        alu_cycles <= w_alu_inc;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            cycle_count <= '0;
            alu_cycles  <= '0;
            r_s         <= '0;
            r_y         <= '0;
            r_x         <= '0;
            r_k         <= '0;
            r_cnt       <= '0;
`ifdef MMUL_CHECKSUM_EN
            checksum    <= '0;
`endif
            r_state     <= S_INIT;
          end
        end

        S_INIT: begin
          if (r_cnt == CW'(2)) begin
            r_cnt   <= '0;
            r_state <= S_RD_A;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        // Request is raised one cycle after entry and held until accepted.
        S_RD_A: begin
          if (!req_valid) begin
            req_valid <= 1'b1;
            req_cmd   <= CMD_RD8;
            req_addr  <= w_a_addr;
            req_wdata <= '0;
          end else if (req_ready) begin
            req_valid <= 1'b0;
            req_cmd   <= '0;
            req_addr  <= '0;
            r_state   <= S_WT_A;
          end
        end

        S_WT_A: begin
          if (resp_valid) begin
            r_a     <= resp_rdata[7:0];
            r_state <= S_RD_B;
          end
        end

        S_RD_B: begin
          if (!req_valid) begin
            req_valid <= 1'b1;
            req_cmd   <= CMD_RD16;
            req_addr  <= w_b_addr;
            req_wdata <= '0;
          end else if (req_ready) begin
            req_valid <= 1'b0;
            req_cmd   <= '0;
            req_addr  <= '0;
            r_state   <= S_WT_B;
          end
        end

        S_WT_B: begin
          if (resp_valid) begin
            r_b     <= resp_rdata[15:0];
            r_state <= S_MUL;
          end
        end

        S_MUL: begin
          if (r_cnt == CW'(MUL_CYC - 1)) begin
            r_cnt   <= '0;
            r_state <= S_ACC;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_ACC: begin
          r_s     <= r_s + 32'(w_prod);
          r_state <= S_STEP;
        end

        S_STEP: begin
          r_k <= r_k + KW'(1);
          if (r_k == KW'(K - 1)) begin
            r_state <= S_WR_C;
          end else begin
            r_state <= S_RD_A;
          end
        end

        S_WR_C: begin
          if (!req_valid) begin
            req_valid <= 1'b1;
            req_cmd   <= CMD_WR32;
            req_addr  <= w_c_addr;
            req_wdata <= r_s;
          end else if (req_ready) begin
            req_valid <= 1'b0;
            req_cmd   <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
`ifdef MMUL_CHECKSUM_EN
            checksum  <= checksum ^ req_wdata;
`endif
            r_state   <= S_WT_C;
          end
        end

        S_WT_C: begin
          if (resp_valid) begin
            r_s <= '0;
            r_k <= '0;
            if (r_x == XW'(N - 1)) begin
              r_x     <= '0;
              r_y     <= r_y + YW'(1);
              r_cnt   <= '0;
              r_state <= S_ROWSTEP;
            end else begin
              r_x     <= r_x + XW'(1);
              r_state <= S_RD_A;
            end
          end
        end

        // Row overhead is charged on every row, including the last one.
        S_ROWSTEP: begin
          if (r_cnt == CW'(1)) begin
            r_cnt <= '0;
            if (r_y == YW'(M)) begin
              busy    <= 1'b0;
              done    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_state <= S_RD_A;
            end
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end

        S_DONE: begin
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmul_access_gen.sv
// tb_mmul_access_gen: self-checking bench for mmul_access_gen in a 2x2x2
// configuration with a byte-array cache model, a table of constant-fill
// vectors, hand-written corner sequences and randomized runs checked against
// a loop-nest reference model.
module tb_mmul_access_gen;

  localparam int unsigned M  = 2;
  localparam int unsigned N  = 2;
  localparam int unsigned K  = 2;
  localparam int unsigned AW = 19;
  localparam int unsigned MC = 5;

  localparam int unsigned B_BASE  = M * K;
  localparam int unsigned C_BASE  = B_BASE + 2 * K * N;
  localparam int unsigned EXP_ALU = 3 + M * N * K * (MC + 2) + 2 * M;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy;
  logic          done;
  logic          req_valid;
  logic          req_ready = 1'b0;
  logic [2:0]    req_cmd;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid = 1'b0;
  logic [31:0]   resp_rdata = '0;
  logic [31:0]   cycle_count;
  logic [31:0]   alu_cycles;
`ifdef MMUL_CHECKSUM_EN
  logic [31:0]   checksum;
`endif

  mmul_access_gen #(
    .M(M), .N(N), .K(K), .A_ADDR(0), .ADDR_W(AW), .MUL_CYC(MC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .busy(busy),
    .done(done),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_cmd(req_cmd),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid),
    .resp_rdata(resp_rdata),
    .cycle_count(cycle_count),
    .alu_cycles(alu_cycles)
`ifdef MMUL_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]    cmd;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
  } req_t;

  typedef struct {
    logic [7:0]  a;
    logic [15:0] b;
    logic [31:0] exp_wdata;
  } vec_t;

  req_t        log_q[$];
  req_t        exp_q[$];
  logic [7:0]  mem[64];
  logic [7:0]  am[M][K];
  logic [15:0] bm[K][N];

  int errors = 0;
  int checks = 0;

  // cache model state
  bit          rand_ready = 1'b0;
  int          lat_max = 0;
  int          hold_low = 0;
  bit          pend = 1'b0;
  int          lat = 0;
  logic [31:0] pend_data = '0;
  bit          prev_stall = 1'b0;
  req_t        prev_req;
  int          stab_err = 0;
  int          stall_cyc = 0;
  int          done_cnt = 0;
  int          busy_cyc = 0;

  task automatic check32(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_read(input logic [2:0] c, input logic [AW-1:0] a);
    logic [5:0] i0;
    logic [5:0] i1;
    i0 = a[5:0];
    i1 = i0 + 6'd1;
    if (c == 3'd1) return {24'd0, mem[i0]};
    if (c == 3'd2) return {16'd0, mem[i1], mem[i0]};
    return 32'd0;
  endfunction

  task automatic load_mem();
    int ad;
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    for (int y = 0; y < M; y++)
      for (int k = 0; k < K; k++) mem[y * K + k] = am[y][k];
    for (int k = 0; k < K; k++)
      for (int x = 0; x < N; x++) begin
        ad = B_BASE + 2 * (k * N + x);
        mem[ad]     = bm[k][x][7:0];
        mem[ad + 1] = bm[k][x][15:8];
      end
  endtask

  task automatic fill_const(input logic [7:0] a, input logic [15:0] b);
    for (int y = 0; y < M; y++) for (int k = 0; k < K; k++) am[y][k] = a;
    for (int k = 0; k < K; k++) for (int x = 0; x < N; x++) bm[k][x] = b;
    load_mem();
  endtask

  // Reference: the textbook loop nest emitting the request stream it implies.
  task automatic build_expected();
    logic [31:0] s;
    req_t r;
    exp_q.delete();
    for (int y = 0; y < M; y++)
      for (int x = 0; x < N; x++) begin
        s = 32'd0;
        for (int k = 0; k < K; k++) begin
          r.cmd = 3'd1; r.addr = AW'(y * K + k); r.wdata = 32'd0;
          exp_q.push_back(r);
          r.cmd = 3'd2; r.addr = AW'(B_BASE + 2 * (k * N + x)); r.wdata = 32'd0;
          exp_q.push_back(r);
          s = s + 32'(am[y][k]) * 32'(bm[k][x]);
        end
        r.cmd = 3'd7; r.addr = AW'(C_BASE + 4 * (y * N + x)); r.wdata = s;
        exp_q.push_back(r);
      end
  endtask

  // Cache model: ready generation, request logging, delayed responses.
  initial begin
    forever begin
      @(negedge clk);
      resp_valid = 1'b0;
      resp_rdata = '0;
      if (pend) begin
        if (lat == 0) begin
          resp_valid = 1'b1;
          resp_rdata = pend_data;
          pend = 1'b0;
        end else begin
          lat--;
        end
      end
      if (prev_stall) begin
        if (!req_valid || req_cmd !== prev_req.cmd || req_addr !== prev_req.addr ||
            req_wdata !== prev_req.wdata) stab_err++;
      end
      if (hold_low > 0) begin
        req_ready = 1'b0;
        if (req_valid) hold_low--;
      end else begin
        req_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (req_valid && req_ready) begin
        req_t r;
        r.cmd = req_cmd; r.addr = req_addr; r.wdata = req_wdata;
        log_q.push_back(r);
        pend = 1'b1;
        lat = $urandom_range(0, lat_max);
        pend_data = mem_read(req_cmd, req_addr);
      end
      if (req_valid && !req_ready) stall_cyc++;
      prev_stall = req_valid && !req_ready;
      prev_req.cmd = req_cmd; prev_req.addr = req_addr; prev_req.wdata = req_wdata;
      if (done) done_cnt++;
      if (busy) busy_cyc++;
    end
  end

  task automatic run_once(input string tag, input int restart_at);
    done_cnt = 0; busy_cyc = 0; stab_err = 0; stall_cyc = 0;
    log_q.delete();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 5000 && done_cnt == 0; i++) begin
      @(negedge clk);
      if (restart_at > 0 && i == restart_at) start = 1'b1;
      else start = 1'b0;
    end
    start = 1'b0;
    repeat (4) @(negedge clk);
    check32({tag, ".done_pulses"}, 32'(done_cnt), 32'd1);
    check32({tag, ".busy_after"}, 32'(busy), 32'd0);
    check32({tag, ".alu_cycles"}, alu_cycles, 32'(EXP_ALU));
    check32({tag, ".cycle_count"}, cycle_count, 32'(busy_cyc));
    check32({tag, ".handshake_stable"}, 32'(stab_err), 32'd0);
  endtask

  task automatic compare_log(input string tag);
    logic [31:0] x;
    x = '0;
    check32({tag, ".req_count"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      check32($sformatf("%s.req%0d.cmd", tag, i), 32'(log_q[i].cmd), 32'(exp_q[i].cmd));
      check32($sformatf("%s.req%0d.addr", tag, i), 32'(log_q[i].addr), 32'(exp_q[i].addr));
      check32($sformatf("%s.req%0d.wdata", tag, i), log_q[i].wdata, exp_q[i].wdata);
      if (exp_q[i].cmd == 3'd7) x = x ^ exp_q[i].wdata;
    end
`ifdef MMUL_CHECKSUM_EN
    check32({tag, ".checksum"}, checksum, x);
`endif
  endtask

  vec_t vecs[5];

  initial begin
    int n_rd8, n_rd16, n_wr;

    vecs[0] = '{a: 8'd1,   b: 16'd2,      exp_wdata: 32'd4};
    vecs[1] = '{a: 8'hFF,  b: 16'hFFFF,   exp_wdata: 32'h01FD_FE02};
    vecs[2] = '{a: 8'd3,   b: 16'd5,      exp_wdata: 32'd30};
    vecs[3] = '{a: 8'h80,  b: 16'h0100,   exp_wdata: 32'h0001_0000};
    vecs[4] = '{a: 8'd0,   b: 16'h1234,   exp_wdata: 32'd0};

    // reset state
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check32("rst.busy", 32'(busy), 32'd0);
    check32("rst.done", 32'(done), 32'd0);
    check32("rst.req_valid", 32'(req_valid), 32'd0);
    check32("rst.req_cmd", 32'(req_cmd), 32'd0);
    check32("rst.req_addr", 32'(req_addr), 32'd0);
    check32("rst.cycle_count", cycle_count, 32'd0);
    check32("rst.alu_cycles", alu_cycles, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // table-driven constant-fill vectors
    for (int v = 0; v < 5; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      fill_const(vecs[v].a, vecs[v].b);
      run_once(tag, 0);
      n_rd8 = 0; n_rd16 = 0; n_wr = 0;
      foreach (log_q[i]) begin
        if (log_q[i].cmd == 3'd1) n_rd8++;
        if (log_q[i].cmd == 3'd2) n_rd16++;
        if (log_q[i].cmd == 3'd7) begin
          n_wr++;
          check32($sformatf("%s.wdata%0d", tag, n_wr), log_q[i].wdata, vecs[v].exp_wdata);
        end
      end
      check32({tag, ".n_read8"}, 32'(n_rd8), 32'd8);
      check32({tag, ".n_read16"}, 32'(n_rd16), 32'd8);
      check32({tag, ".n_write32"}, 32'(n_wr), 32'd4);
`ifdef MMUL_CHECKSUM_EN
      check32({tag, ".checksum"}, checksum, 32'd0);
`endif
      if (v == 0 && log_q.size() >= 5) begin
        check32("first.A_addr", 32'(log_q[0].addr), 32'h000);
        check32("first.B_addr", 32'(log_q[1].addr), 32'h004);
        check32("first.C_addr", 32'(log_q[4].addr), 32'h00C);
      end
    end

    // ready held low for 7 cycles on the very first request
    fill_const(8'd1, 16'd2);
    build_expected();
    hold_low = 7;
    run_once("stall", 0);
    check32("stall.cycles", 32'(stall_cyc), 32'd7);
    compare_log("stall");

    // start pulsed mid-run must not disturb the sequence
    run_once("restart_ignored", 30);
    compare_log("restart_ignored");

    // reset while in the multiply stall, then restart from A(0,0)
    done_cnt = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 400 && alu_cycles != 32'd4; i++) @(negedge clk);
    check32("rstmul.reached_mul", alu_cycles, 32'd4);
    reset = 1'b1;
    @(negedge clk);
    check32("rstmul.busy", 32'(busy), 32'd0);
    check32("rstmul.req_valid", 32'(req_valid), 32'd0);
    check32("rstmul.req_addr", 32'(req_addr), 32'd0);
    check32("rstmul.cycle_count", cycle_count, 32'd0);
    check32("rstmul.alu_cycles", alu_cycles, 32'd0);
    reset = 1'b0;
    pend = 1'b0;
    @(negedge clk);
    run_once("rstmul.rerun", 0);
    compare_log("rstmul.rerun");

    // randomized contents, random ready and response latency
    rand_ready = 1'b1;
    lat_max = 2;
    for (int it = 0; it < 6; it++) begin
      for (int y = 0; y < M; y++) for (int k = 0; k < K; k++) am[y][k] = 8'($urandom);
      for (int k = 0; k < K; k++) for (int x = 0; x < N; x++) bm[k][x] = 16'($urandom);
      load_mem();
      build_expected();
      run_once($sformatf("rand%0d", it), 0);
      compare_log($sformatf("rand%0d", it));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors + 1, checks);
    $fatal(1);
  end

endmodule
